// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline hazard-control slice.
package pipe_pkg;

  // Default geometry of the back end tracked by the hazard unit
  localparam int DEF_REG_AW   = 3;
  localparam int DEF_DEPTH    = 3;
  localparam int DEF_LOAD_LAT = 2;

  // Widest register address a shadow entry can hold; narrower cores zero-extend
  localparam int MAX_REG_AW = 16;

  // Forward select value meaning "take the operand from the register file"
  localparam int FWD_RF = 0;

  // One shadow-pipeline slot: valid, writes-register, destination, is-load
  typedef struct packed {
    logic                  v;
    logic                  we;
    logic [MAX_REG_AW-1:0] rd;
    logic                  ld;
  } shadow_entry_t;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Priority match of one decode source operand against all shadow entries.
// Returns the youngest forwardable producer and flags a too-young load.
module pipe_fwd_sel
  import pipe_pkg::*;
#(
  parameter int REG_AW   = DEF_REG_AW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int FW       = $clog2(DEPTH + 1)
) (
  input  shadow_entry_t [DEPTH-1:0] entries,
  input  logic [REG_AW-1:0]         src,
  input  logic                      src_en,
  output logic [FW-1:0]             fwd_sel,
  output logic                      load_hit
);

  logic match;

  // Walk from oldest to youngest so the youngest forwardable match is written last
  always_comb begin
    fwd_sel  = FW'(FWD_RF);
    load_hit = 1'b0;
    match    = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      match = entries[k].v & entries[k].we & src_en &
              (entries[k].rd == MAX_REG_AW'(src));
      if (match && (!entries[k].ld || (k + 1) >= LOAD_LAT)) begin
        fwd_sel = FW'(k + 1);
      end
      if (match && entries[k].ld && (k + 1) < LOAD_LAT) begin
        load_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard control for the pipelined core: shadow pipeline of destination tags,
// operand forwarding selects, load-use stall and branch flush.
// Optional statistics counters are built when PIPE_HAZARD_STATS_EN is defined.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW   = DEF_REG_AW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int FW       = $clog2(DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Hold,
  input  logic              Id_valid,
  input  logic [REG_AW-1:0] Id_rs1,
  input  logic [REG_AW-1:0] Id_rs2,
  input  logic              Id_rs1_en,
  input  logic              Id_rs2_en,
  input  logic [REG_AW-1:0] Id_rd,
  input  logic              Id_we,
  input  logic              Id_load,
  input  logic              Ex_br_taken,
  output logic              Stall,
  output logic              Flush,
  output logic [FW-1:0]     Fwd_a,
  output logic [FW-1:0]     Fwd_b
`ifdef PIPE_HAZARD_STATS_EN
  ,
  output logic [15:0]       Stall_cnt,
  output logic [15:0]       Flush_cnt
`endif
);

  shadow_entry_t [DEPTH-1:0] shadow_q;
  shadow_entry_t [DEPTH-1:0] shadow_d;
  shadow_entry_t             dec_tag;
  logic [FW-1:0]             fwd_a_raw;
  logic [FW-1:0]             fwd_b_raw;
  logic                      hit_a;
  logic                      hit_b;
  logic                      accept;

  pipe_fwd_sel #(
    .REG_AW  (REG_AW),
    .DEPTH   (DEPTH),
    .LOAD_LAT(LOAD_LAT),
    .FW      (FW)
  ) u_sel_rs1 (
    .entries (shadow_q),
    .src     (Id_rs1),
    .src_en  (Id_rs1_en),
    .fwd_sel (fwd_a_raw),
    .load_hit(hit_a)
  );

  pipe_fwd_sel #(
    .REG_AW  (REG_AW),
    .DEPTH   (DEPTH),
    .LOAD_LAT(LOAD_LAT),
    .FW      (FW)
  ) u_sel_rs2 (
    .entries (shadow_q),
    .src     (Id_rs2),
    .src_en  (Id_rs2_en),
    .fwd_sel (fwd_b_raw),
    .load_hit(hit_b)
  );

  // Decode outputs; a taken branch wins over a load-use stall
  always_comb begin
    Flush  = Ex_br_taken & shadow_q[0].v;
    Stall  = Id_valid & (hit_a | hit_b) & ~Flush;
    Fwd_a  = Id_valid ? fwd_a_raw : FW'(FWD_RF);
    Fwd_b  = Id_valid ? fwd_b_raw : FW'(FWD_RF);
    accept = Id_valid & ~Stall & ~Flush;
  end

  // Build the decode tag and advance the shadow pipeline unless frozen
  always_comb begin
    dec_tag    = '0;
    dec_tag.v  = 1'b1;
    dec_tag.we = Id_we;
    dec_tag.rd = MAX_REG_AW'(Id_rd);
    dec_tag.ld = Id_load;
    shadow_d   = shadow_q;
    if (!Hold) begin
      shadow_d[0] = accept ? dec_tag : '0;
      for (int k = 1; k < DEPTH; k++) begin
        shadow_d[k] = shadow_q[k-1];
      end
    end
  end

  // Shadow pipeline register, cleared to bubbles on reset
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

`ifdef PIPE_HAZARD_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;
  logic [15:0] flush_cnt_q;
  logic [15:0] flush_cnt_d;

  // Saturating event counters that only count unfrozen cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!Hold) begin
      if (Stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      if (Flush && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // Counter registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Stall_cnt = stall_cnt_q;
  assign Flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Testbench for pipe_hazard_unit: directed hazard scenarios followed by
// randomized traffic against a behavioural model of the back-end stages.
module tb_pipe_hazard_unit;

  localparam int REG_AW   = 3;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 2;
  localparam int FW       = $clog2(DEPTH + 1);

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              Hold;
  logic              Id_valid;
  logic [REG_AW-1:0] Id_rs1;
  logic [REG_AW-1:0] Id_rs2;
  logic              Id_rs1_en;
  logic              Id_rs2_en;
  logic [REG_AW-1:0] Id_rd;
  logic              Id_we;
  logic              Id_load;
  logic              Ex_br_taken;
  logic              Stall;
  logic              Flush;
  logic [FW-1:0]     Fwd_a;
  logic [FW-1:0]     Fwd_b;
`ifdef PIPE_HAZARD_STATS_EN
  logic [15:0]       Stall_cnt;
  logic [15:0]       Flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Model: what instruction currently occupies each back-end stage 1..DEPTH
  bit m_v  [1:DEPTH];
  bit m_we [1:DEPTH];
  int m_rd [1:DEPTH];
  bit m_ld [1:DEPTH];
  int m_stall_cnt;
  int m_flush_cnt;

  pipe_hazard_unit #(
    .REG_AW  (REG_AW),
    .DEPTH   (DEPTH),
    .LOAD_LAT(LOAD_LAT),
    .FW      (FW)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Hold       (Hold),
    .Id_valid   (Id_valid),
    .Id_rs1     (Id_rs1),
    .Id_rs2     (Id_rs2),
    .Id_rs1_en  (Id_rs1_en),
    .Id_rs2_en  (Id_rs2_en),
    .Id_rd      (Id_rd),
    .Id_we      (Id_we),
    .Id_load    (Id_load),
    .Ex_br_taken(Ex_br_taken),
    .Stall      (Stall),
    .Flush      (Flush),
    .Fwd_a      (Fwd_a),
    .Fwd_b      (Fwd_b)
`ifdef PIPE_HAZARD_STATS_EN
    ,
    .Stall_cnt  (Stall_cnt),
    .Flush_cnt  (Flush_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  // Does the instruction in stage k write the given source register?
  function automatic bit writes(int k, int src, bit en);
    return en && m_v[k] && m_we[k] && (m_rd[k] == src);
  endfunction

  function automatic int expFwd(int src, bit en);
    if (!Id_valid) return 0;
    for (int k = 1; k <= DEPTH; k++)
      if (writes(k, src, en) && (!m_ld[k] || k >= LOAD_LAT)) return k;
    return 0;
  endfunction

  function automatic bit expFlush();
    return Ex_br_taken && m_v[1];
  endfunction

  function automatic bit expStall();
    if (!Id_valid || expFlush()) return 0;
    for (int k = 1; k < LOAD_LAT; k++)
      if (m_ld[k] && (writes(k, int'(Id_rs1), Id_rs1_en) ||
                      writes(k, int'(Id_rs2), Id_rs2_en))) return 1;
    return 0;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "_stall"}, 32'(Stall), 32'(expStall()));
    checkVal({tag, "_flush"}, 32'(Flush), 32'(expFlush()));
    checkVal({tag, "_fwd_a"}, 32'(Fwd_a), 32'(expFwd(int'(Id_rs1), Id_rs1_en)));
    checkVal({tag, "_fwd_b"}, 32'(Fwd_b), 32'(expFwd(int'(Id_rs2), Id_rs2_en)));
`ifdef PIPE_HAZARD_STATS_EN
    checkVal({tag, "_stall_cnt"}, 32'(Stall_cnt), 32'(m_stall_cnt));
    checkVal({tag, "_flush_cnt"}, 32'(Flush_cnt), 32'(m_flush_cnt));
`endif
  endtask

  task automatic applyStimulus(input bit v, input int rs1, input bit e1, input int rs2,
                               input bit e2, input int rd, input bit we, input bit ld,
                               input bit br, input bit hold);
    Id_valid    = v;
    Id_rs1      = REG_AW'(rs1);
    Id_rs1_en   = e1;
    Id_rs2      = REG_AW'(rs2);
    Id_rs2_en   = e2;
    Id_rd       = REG_AW'(rd);
    Id_we       = we;
    Id_load     = ld;
    Ex_br_taken = br;
    Hold        = hold;
  endtask

  task automatic clearModel();
    for (int k = 1; k <= DEPTH; k++) begin
      m_v[k] = 0; m_we[k] = 0; m_rd[k] = 0; m_ld[k] = 0;
    end
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  task automatic doReset();
    Reset_n = 1'b0;
    clearModel();
  endtask

  // Advance the model by one clock edge using its own stall/flush decisions
  task automatic updateModel();
    bit st;
    bit fl;
    if (!Reset_n || Hold) return;
    st = expStall();
    fl = expFlush();
    if (st && m_stall_cnt < 65535) m_stall_cnt++;
    if (fl && m_flush_cnt < 65535) m_flush_cnt++;
    for (int k = DEPTH; k >= 2; k--) begin
      m_v[k] = m_v[k-1]; m_we[k] = m_we[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1];
    end
    m_v[1]  = Id_valid && !st && !fl;
    m_we[1] = Id_we;
    m_rd[1] = int'(Id_rd);
    m_ld[1] = Id_load;
  endtask

  task automatic cycle();
    @(negedge Clk);
    checkOutput("cyc");
    @(posedge Clk);
    updateModel();
    #1;
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    doReset();
    #1;
    checkOutput("reset");
    checkVal("reset_flush_br", 32'(Flush), 32'd0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    $display("[TB] back-to-back ALU forwarding");
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    cycle();
    applyStimulus(1, 1, 1, 0, 0, 2, 1, 0, 0, 0);
    #1;
    checkVal("t1_fwd_a", 32'(Fwd_a), 32'd1);
    checkVal("t1_stall", 32'(Stall), 32'd0);
    cycle();

    $display("[TB] load-use stall");
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    cycle();
    applyStimulus(1, 3, 1, 0, 0, 4, 1, 0, 0, 0);
    #1;
    checkVal("t2_stall_on", 32'(Stall), 32'd1);
    cycle();
    #1;
    checkVal("t2_stall_off", 32'(Stall), 32'd0);
    checkVal("t2_fwd_a", 32'(Fwd_a), 32'd2);
    cycle();

    $display("[TB] youngest writer wins");
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    cycle();
    applyStimulus(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    cycle();
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    cycle();
    applyStimulus(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    #1;
    checkVal("t3_fwd_b", 32'(Fwd_b), 32'd1);
    cycle();

    $display("[TB] flush beats load-use stall");
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    cycle();
    applyStimulus(1, 3, 1, 0, 0, 7, 1, 0, 1, 0);
    #1;
    checkVal("t4_flush", 32'(Flush), 32'd1);
    checkVal("t4_stall", 32'(Stall), 32'd0);
    cycle();
    applyStimulus(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkVal("t4_discarded", 32'(Fwd_a), 32'd0);
    cycle();

    $display("[TB] hold during stall");
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    cycle();
    applyStimulus(1, 3, 1, 0, 0, 4, 1, 0, 0, 0);
    #1;
    checkVal("t5_stall_pre", 32'(Stall), 32'd1);
    for (int i = 0; i < 3; i++) begin
      Hold = 1'b1;
      #1;
      checkVal("t5_stall_held", 32'(Stall), 32'd1);
      cycle();
    end
    Hold = 1'b0;
    #1;
    checkVal("t5_stall_last", 32'(Stall), 32'd1);
    cycle();
    #1;
    checkVal("t5_stall_rel", 32'(Stall), 32'd0);
    checkVal("t5_fwd_a", 32'(Fwd_a), 32'd2);
    cycle();

    $display("[TB] async reset with full pipeline");
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    cycle();
    applyStimulus(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    cycle();
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    cycle();
    applyStimulus(1, 1, 1, 2, 1, 0, 0, 0, 1, 0);
    #1;
    checkVal("t6_fwd_a_pre", 32'(Fwd_a), 32'd3);
    checkVal("t6_fwd_b_pre", 32'(Fwd_b), 32'd2);
    doReset();
    #1;
    checkVal("t6_fwd_a_rst", 32'(Fwd_a), 32'd0);
    checkVal("t6_fwd_b_rst", 32'(Fwd_b), 32'd0);
    checkVal("t6_flush_rst", 32'(Flush), 32'd0);
    checkVal("t6_stall_rst", 32'(Stall), 32'd0);
`ifdef PIPE_HAZARD_STATS_EN
    checkVal("t6_stall_cnt_rst", 32'(Stall_cnt), 32'd0);
    checkVal("t6_flush_cnt_rst", 32'(Flush_cnt), 32'd0);
`endif
    cycle();
    Reset_n = 1'b1;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(99) < 85, $urandom_range(3), 1'($urandom),
                    $urandom_range(3), 1'($urandom), $urandom_range(3),
                    $urandom_range(99) < 70, $urandom_range(99) < 35,
                    $urandom_range(99) < 10, $urandom_range(99) < 15);
      if ($urandom_range(99) == 0) doReset();
      else Reset_n = 1'b1;
      #1;
      checkOutput("rand");
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard-control block for the pipelined processor core. It generalises the fixed 8-bit pipeline's hazard handling to configurable register-address width, back-end depth and load latency. It keeps a shadow pipeline of destination-register tags and uses it to generate operand-forwarding selects, load-use stalls and branch flushes for the decode stage. It sits between the decode stage and the execute/memory/writeback stages and drives their enables and the operand multiplexers.

## Interface
- REG_AW, 3, register-address width (2^REG_AW registers)
- DEPTH, 3, back-end stages tracked after decode (stage 1 = EX … stage DEPTH = WB)
- LOAD_LAT, 2, first stage index whose load result is forwardable (1 ≤ LOAD_LAT ≤ DEPTH)
- FW, $clog2(DEPTH+1), forward-select width (derived)
- Clk  in  1  clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Hold  in  1  external freeze (memory wait); shadow pipeline holds
- Id_valid  in  1  decode holds a real instruction
- Id_rs1, Id_rs2  in  REG_AW  decode source registers
- Id_rs1_en, Id_rs2_en  in  1  source actually read
- Id_rd  in  REG_AW  decode destination
- Id_we  in  1  decode instruction writes Id_rd
- Id_load  in  1  decode instruction is a load
- Ex_br_taken  in  1  branch resolved taken in stage 1
- Stall  out  1  freeze fetch/decode; insert bubble into stage 1
- Flush  out  1  kill fetch/decode contents
- Fwd_a, Fwd_b  out  FW  0 = register file, k = result of stage k

## Operation
- Shadow pipeline: DEPTH entries {v, we, rd, ld}; entry k mirrors stage k.
- Per edge (Hold=0): entry k+1 ← entry k; entry 1 ← decode tag if Id_valid & ~Stall & ~Flush, else bubble (v=0); entry DEPTH retires.
- Hold=1: all entries unchanged; outputs still evaluated from current state.
- Match on stage k: v & we & rd == source & source_en.
- Forwarding: Fwd = smallest k with a match and (~ld or k ≥ LOAD_LAT); 0 if none. Youngest writer always wins.
- Load-use stall: Stall = 1 if any match on stage k < LOAD_LAT with ld=1 (either source), and Flush=0.
- Stall releases on its own: bubbles advance the load until k ≥ LOAD_LAT; at most LOAD_LAT-1 consecutive stall cycles per load.
- Flush = Ex_br_taken & entry1.v. Flush has priority over Stall: Stall forced 0 and the decode tag is discarded.
- Id_valid=0: Stall=0, Fwd_a=Fwd_b=0.
- Register 0 is not special; matches on rd=0 forward normally.

## Timing
- Stall, Flush, Fwd_a, Fwd_b: combinational from shadow state and decode inputs; valid in the same cycle.
- Decode tag visible in entry 1 one edge after acceptance, in entry k after k edges (excluding Hold cycles).
- Reset_n low: all entries invalid immediately (async); Stall=0, Fwd_a=Fwd_b=0, Flush=0 regardless of Ex_br_taken. Stats counters reset to 0.
- Reset released mid-stream: the first accepted decode tag enters on the first edge with Reset_n=1.

## Configuration
- PIPE_HAZARD_STATS_EN defined: adds outputs Stall_cnt and Flush_cnt, 16 bits each. They increment on each edge where Stall or Flush is high and Hold=0, and saturate at 16'hFFFF.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package pipe_pkg: shadow-entry struct typedef, FWD_RF=0 constant, and default REG_AW/DEPTH/LOAD_LAT.
- One sub-module, pipe_fwd_sel: priority match over DEPTH entries for one source, returning a forward select and a load-use hit. It is instantiated twice (rs1, rs2).

## Test plan
- ADD r1 then ADD r2←r1 back-to-back → Fwd_a=1 in cycle 2, no Stall.
- LOAD r3 then ADD r4←r3 → Stall=1 for exactly 1 cycle, then Fwd_a=2.
- r5 written in stages 1 and 3, consumer reads r5 → Fwd_b=1 (youngest wins).
- LOAD r3 + dependent consumer with Ex_br_taken=1 in the same cycle → Flush=1, Stall=0; consumer never appears in entry 1.
- Hold=1 for 3 cycles mid-stall → entries frozen, Stall stays 1; releases 1 cycle after Hold drops.
- Reset_n pulsed low with 3 valid entries → Fwd_a=Fwd_b=0 immediately; counters read 0 (stats build).
